teclado_ps2_rx: RTL and testbench

PS/2 keyboard receiver that produces the `Estado` scan-code byte consumed by the display multiplexer and the time/date editing logic. It samples the keyboard's open-collector clock/data lines in the system clock domain and deframes 11-bit device-to-host frames. It strips the `F0` (break) and `E0` (extended) prefixes, holds the last pressed key on `Estado`, and emits one-cycle strobes for press and release events.

---
 rtl/teclado_ps2_rx_if.sv | 32 +++
 rtl/teclado_ps2_rx.sv | 240 ++++++++++++++++++++++++
 tb/tb_teclado_ps2_rx.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/teclado_ps2_rx_if.sv
// ---------------------------------------------------------------------------
// teclado_ps2_rx_if
// Bundle between the PS/2 keyboard lines and the scan-code consumers.
//   ps2_clk, ps2_data : keyboard open-collector lines (asynchronous)
//   Estado            : scan code of the last make event
//   codigo            : last completed non-prefix code (make or break)
//   extendido         : codigo was preceded by an E0 prefix
//   make_stb          : one-cycle pulse per accepted make code
//   break_stb         : one-cycle pulse per accepted break code
//   frame_err         : one-cycle pulse per rejected / timed-out frame
// Modports: master = keyboard side / host logic, slave = receiver.
// ---------------------------------------------------------------------------
interface teclado_ps2_rx_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] Estado;
  logic [7:0] codigo;
  logic       extendido;
  logic       make_stb;
  logic       break_stb;
  logic       frame_err;

  modport master (
    output ps2_clk, ps2_data,
    input  Estado, codigo, extendido, make_stb, break_stb, frame_err
  );

  modport slave (
    input  ps2_clk, ps2_data,
    output Estado, codigo, extendido, make_stb, break_stb, frame_err
  );
endinterface

// File: rtl/teclado_ps2_rx.sv
// ---------------------------------------------------------------------------
// teclado_ps2_rx
// PS/2 keyboard receiver. Synchronizes and filters the keyboard lines,
// deframes 11-bit device-to-host frames, strips E0/F0 prefixes and reports
// make/break events.
// Ports:
//   clk      : system clock, all logic on rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : teclado_ps2_rx_if.slave (PS/2 lines in, scan-code outputs)
// Parameters:
//   FILTER_LEN  : identical samples needed before filtered ps2_clk changes
//   TIMEOUT_CYC : max clk cycles between falling edges inside a frame
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | waiting for a falling edge with data=0 (start bit)
// S_DATA   | shifting in 8 data bits, LSB first
// S_PARITY | capturing the parity bit
// S_STOP   | checking stop bit and odd parity, then processing the byte
// ---------------------------------------------------------------------------
module teclado_ps2_rx #(
  parameter int unsigned FILTER_LEN  = 8,
  parameter int unsigned TIMEOUT_CYC = 20000
) (
  input  logic               clk,
  input  logic               reset_n,
  teclado_ps2_rx_if.slave    bus
);

  localparam int unsigned FW = (FILTER_LEN  > 1) ? $clog2(FILTER_LEN)      : 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  // synchronizers (reset to the idle-high line level)
  logic clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
  logic dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;

  // clock glitch filter
  logic [FW-1:0] flt_cnt_q, flt_cnt_d;
  logic          flt_q, flt_d;
  logic          fall;

  // deframer
  state_t        state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          par_q, par_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          frame_ok;
  logic          tmo_expired;

  // byte processing / outputs
  logic [7:0]    estado_q, estado_d;
  logic [7:0]    codigo_q, codigo_d;
  logic          ext_q, ext_d;
  logic          make_q, make_d;
  logic          brk_q, brk_d;
  logic          err_q, err_d;
  logic          pend_ext_q, pend_ext_d;
  logic          pend_brk_q, pend_brk_d;

  // -------------------------------------------------------------------------
  // Input conditioning
  // -------------------------------------------------------------------------
  always_comb begin
    clk_s1_d = bus.ps2_clk;
    clk_s2_d = clk_s1_q;
    dat_s1_d = bus.ps2_data;
    dat_s2_d = dat_s1_q;
  end

  // The counter tracks how many consecutive samples disagree with the
  // filtered level; any agreeing sample restarts the count, so short
  // glitches never reach the terminal value.
  always_comb begin
    flt_cnt_d = '0;
    flt_d     = flt_q;
    if (clk_s2_q != flt_q) begin
      if (flt_cnt_q == FW'(FILTER_LEN - 1)) begin
        flt_d = clk_s2_q;
      end else begin
        flt_cnt_d = flt_cnt_q + 1'b1;
      end
    end
  end

  // Edge is taken in the same cycle the filter decides to flip, so the
  // deframer acts without an extra register stage.
  assign fall = flt_q & ~flt_d;

  // -------------------------------------------------------------------------
  // Deframer FSM and byte processing
  // -------------------------------------------------------------------------
  assign frame_ok    = dat_s2_q & (^{shreg_q, par_q});
  assign tmo_expired = (state_q != S_IDLE) && !fall && (tmo_q <= TW'(1));

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    par_d      = par_q;
    tmo_d      = '0;
    estado_d   = estado_q;
    codigo_d   = codigo_q;
    ext_d      = ext_q;
    make_d     = 1'b0;
    brk_d      = 1'b0;
    err_d      = 1'b0;
    pend_ext_d = pend_ext_q;
    pend_brk_d = pend_brk_q;

    case (state_q)
      S_IDLE: begin
        if (fall && !dat_s2_q) begin
          state_d   = S_DATA;
          bit_cnt_d = 3'd0;
        end
      end

      S_DATA: begin
        if (fall) begin
          shreg_d   = {dat_s2_q, shreg_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = S_PARITY;
          end
        end
      end

      S_PARITY: begin
        if (fall) begin
          par_d   = dat_s2_q;
          state_d = S_STOP;
        end
      end

      S_STOP: begin
        if (fall) begin
          state_d = S_IDLE;
          if (!frame_ok) begin
            err_d      = 1'b1;
            pend_ext_d = 1'b0;
            pend_brk_d = 1'b0;
          end else if (shreg_q == 8'hE0) begin
            pend_ext_d = 1'b1;
          end else if (shreg_q == 8'hF0) begin
            pend_brk_d = 1'b1;
          end else begin
            codigo_d   = shreg_q;
            ext_d      = pend_ext_q;
            if (pend_brk_q) begin
              brk_d = 1'b1;
            end else begin
              make_d   = 1'b1;
              estado_d = shreg_q;
            end
            pend_ext_d = 1'b0;
            pend_brk_d = 1'b0;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    // A stalled keyboard drops the partial byte but keeps prefix flags.
    if (tmo_expired) begin
      state_d = S_IDLE;
      err_d   = 1'b1;
    end

    // Inter-edge timer: reloaded on every falling edge, counts down while
    // a frame is in progress.
    if (state_d != S_IDLE) begin
      if (fall) begin
        tmo_d = TW'(TIMEOUT_CYC);
      end else if (tmo_q != '0) begin
        tmo_d = tmo_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
      flt_cnt_q  <= '0;
      flt_q      <= 1'b1;
      state_q    <= S_IDLE;
      bit_cnt_q  <= 3'd0;
      shreg_q    <= 8'h00;
      par_q      <= 1'b0;
      tmo_q      <= '0;
      estado_q   <= 8'h00;
      codigo_q   <= 8'h00;
      ext_q      <= 1'b0;
      make_q     <= 1'b0;
      brk_q      <= 1'b0;
      err_q      <= 1'b0;
      pend_ext_q <= 1'b0;
      pend_brk_q <= 1'b0;
    end else begin
      clk_s1_q   <= clk_s1_d;
      clk_s2_q   <= clk_s2_d;
      dat_s1_q   <= dat_s1_d;
      dat_s2_q   <= dat_s2_d;
      flt_cnt_q  <= flt_cnt_d;
      flt_q      <= flt_d;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      par_q      <= par_d;
      tmo_q      <= tmo_d;
      estado_q   <= estado_d;
      codigo_q   <= codigo_d;
      ext_q      <= ext_d;
      make_q     <= make_d;
      brk_q      <= brk_d;
      err_q      <= err_d;
      pend_ext_q <= pend_ext_d;
      pend_brk_q <= pend_brk_d;
    end
  end

  assign bus.Estado    = estado_q;
  assign bus.codigo    = codigo_q;
  assign bus.extendido = ext_q;
  assign bus.make_stb  = make_q;
  assign bus.break_stb = brk_q;
  assign bus.frame_err = err_q;

endmodule

// File: tb/tb_teclado_ps2_rx.sv
// ---------------------------------------------------------------------------
// tb_teclado_ps2_rx
// Drives PS/2 frames at 80 system clocks per bit (12.5 kHz line clock with a
// 1 MHz system clock) and compares the receiver against an event-level
// model of the keyboard protocol.
// ---------------------------------------------------------------------------
module tb_teclado_ps2_rx;

  logic clk = 1'b0;
  logic reset_n;

  always #500 clk = ~clk;

  teclado_ps2_rx_if bus ();

  teclado_ps2_rx #(
    .FILTER_LEN  (8),
    .TIMEOUT_CYC (20000)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // strobe monitor
  int mon_make = 0;
  int mon_brk  = 0;
  int mon_err  = 0;

  always @(negedge clk) begin
    if (bus.make_stb  === 1'b1) mon_make++;
    if (bus.break_stb === 1'b1) mon_brk++;
    if (bus.frame_err === 1'b1) mon_err++;
    if ((int'(bus.make_stb) + int'(bus.break_stb) + int'(bus.frame_err)) > 1)
      chk("strobe_excl", 32'(int'(bus.make_stb) + int'(bus.break_stb) + int'(bus.frame_err)), 32'd1);
  end

  // reference model: protocol-level event rules
  logic [7:0] m_estado, m_codigo;
  logic       m_ext, m_pext, m_pbrk;
  int         m_make, m_brk, m_err;

  task automatic model_reset();
    m_estado = 8'h00; m_codigo = 8'h00; m_ext = 1'b0;
    m_pext = 1'b0; m_pbrk = 1'b0;
  endtask

  task automatic model_byte(input logic [7:0] b, input bit bad);
    if (bad) begin
      m_err++;
      m_pext = 1'b0; m_pbrk = 1'b0;
    end else if (b == 8'hE0) begin
      m_pext = 1'b1;
    end else if (b == 8'hF0) begin
      m_pbrk = 1'b1;
    end else begin
      m_codigo = b;
      m_ext    = m_pext;
      if (m_pbrk) m_brk++;
      else begin
        m_make++;
        m_estado = b;
      end
      m_pext = 1'b0; m_pbrk = 1'b0;
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Sends the first nbits bits of a frame; odd parity unless bad_par.
  task automatic send_bits(input logic [7:0] b, input bit bad_par, input int nbits);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      bus.ps2_data = f[i];
      wait_clk(20);
      bus.ps2_clk = 1'b0;
      wait_clk(40);
      bus.ps2_clk = 1'b1;
      wait_clk(20);
    end
    bus.ps2_data = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_par);
    send_bits(b, bad_par, 11);
    model_byte(b, bad_par);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".estado"}, 32'(bus.Estado), 32'(m_estado));
    chk({tag, ".codigo"}, 32'(bus.codigo), 32'(m_codigo));
    chk({tag, ".ext"},    32'(bus.extendido), 32'(m_ext));
    chk({tag, ".n_make"}, 32'(mon_make), 32'(m_make));
    chk({tag, ".n_brk"},  32'(mon_brk),  32'(m_brk));
    chk({tag, ".n_err"},  32'(mon_err),  32'(m_err));
  endtask

  initial begin
    logic [7:0] kb;
    bit         ext, brk, bad;

    m_make = 0; m_brk = 0; m_err = 0;
    model_reset();
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    reset_n      = 1'b0;
    wait_clk(5);
    check_all("reset");
    chk("reset.make_stb", 32'(bus.make_stb), 32'd0);
    reset_n = 1'b1;
    wait_clk(50);

    // press
    send_byte(8'h6C, 1'b0);
    check_all("press");

    // release
    send_byte(8'hF0, 1'b0);
    check_all("brk_prefix");
    send_byte(8'h75, 1'b0);
    check_all("release");

    // extended press / release
    send_byte(8'hE0, 1'b0);
    send_byte(8'h75, 1'b0);
    check_all("ext_press");
    send_byte(8'hE0, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h75, 1'b0);
    check_all("ext_release");

    // parity error, then recovery
    send_byte(8'h6C, 1'b1);
    check_all("parity_err");
    send_byte(8'h1C, 1'b0);
    check_all("after_parity");

    // orphan prefix killed by a bad frame must not attach to the next key
    send_byte(8'hF0, 1'b0);
    send_byte(8'h33, 1'b1);
    send_byte(8'h2B, 1'b0);
    check_all("orphan_prefix");

    // timeout after 4 data bits
    send_bits(8'h6C, 1'b0, 5);
    wait_clk(20200);
    m_err++;
    check_all("timeout");

    // short glitch on ps2_clk
    bus.ps2_clk = 1'b0;
    wait_clk(3);
    bus.ps2_clk = 1'b1;
    wait_clk(100);
    check_all("glitch");
    send_byte(8'h6C, 1'b0);
    check_all("after_glitch");

    // reset in the middle of data bit 5
    send_bits(8'h75, 1'b0, 6);
    bus.ps2_data = 1'b0;
    wait_clk(20);
    bus.ps2_clk = 1'b0;
    wait_clk(20);
    reset_n = 1'b0;
    wait_clk(2);
    model_reset();
    check_all("mid_reset");
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    wait_clk(20);
    reset_n = 1'b1;
    wait_clk(40);
    check_all("post_reset");
    send_byte(8'h75, 1'b0);
    check_all("reset_recover");

    // randomized key events
    for (int n = 0; n < 10; n++) begin
      kb = 8'($urandom_range(1, 255));
      if (kb == 8'hE0 || kb == 8'hF0) kb = 8'h1C;
      ext = ($urandom % 2) == 1;
      brk = ($urandom % 2) == 1;
      bad = ($urandom % 6) == 0;
      if (ext) send_byte(8'hE0, 1'b0);
      if (brk) send_byte(8'hF0, 1'b0);
      send_byte(kb, bad);
      check_all($sformatf("rand%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
